// File: rtl/pipe_mem_arb.sv
// ============================================================================
// pipe_mem_arb : fetch/data arbiter onto one single-port memory, fixed latency
// Revision     : 1.0
// ============================================================================
`default_nettype none

module pipe_mem_arb #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] LAT    = 3'(MEM_LAT);
  localparam logic [1:0] STARVE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  starve_q, starve_d;
  logic        win_data_q, win_data_d;

  logic        m_en_q, m_en_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        req_any;
  logic        grant_data;
  logic        last_beat;

  // Data normally wins; a fetch that has lost three times in a row goes first.
  assign req_any    = i_req | d_req;
  assign grant_data = d_req & ~(i_req & (starve_q == STARVE));
  assign last_beat  = (state_q == S_BUSY) && (cnt_q == LAT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      starve_q   <= 2'd0;
      win_data_q <= 1'b0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= 32'd0;
      m_wdata_q  <= 32'd0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      i_rdata_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      win_data_q <= win_data_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    win_data_d = win_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_d    = S_BUSY;
          cnt_d      = 3'd1;
          win_data_d = grant_data;
          if (grant_data && i_req) begin
            starve_d = (starve_q == STARVE) ? STARVE : starve_q + 2'd1;
          end else begin
            starve_d = 2'd0;
          end
        end
      end
      S_BUSY: begin
        if (last_beat) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the registered memory-side strobes, acks and read data.
  always_comb begin
    m_en_d    = m_en_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          m_en_d = 1'b1;
          if (grant_data) begin
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_we ? d_wdata : 32'd0;
          end else begin
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = 32'd0;
          end
        end
      end
      S_BUSY: begin
        if (last_beat) begin
          m_en_d = 1'b0;
          m_we_d = 1'b0;
          if (win_data_q) begin
            d_ack_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = m_rdata;
            end
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = m_rdata;
          end
        end
      end
      default: begin
        m_en_d = 1'b0;
        m_we_d = 1'b0;
      end
    endcase
  end

  assign m_en      = m_en_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign stall_if  = i_req & ~i_ack_q;
  assign stall_mem = d_req & ~d_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_mem_arb.sv
// ============================================================================
// tb_pipe_mem_arb : directed self-checking bench for pipe_mem_arb (MEM_LAT=2)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_mem_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        i_ack, d_ack, m_en, m_we, busy, stall_if, stall_mem;

  logic        use_const;
  logic [31:0] const_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  // Memory model: either a fixed word or a simple function of the address.
  assign m_rdata = use_const ? const_rdata : (m_addr ^ 32'h5A5A_0000);

  pipe_mem_arb #(.MEM_LAT(2)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock); #1;
    end
  endtask

  logic       prev_en;
  int         gi;
  logic       gdata [8];
  logic       exp_d [8];

  initial begin
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
    use_const = 1'b1; const_rdata = 32'hFFFF_FFFF;
    idle_cycles(3);

    check("rst_m_en",    m_en,    0);
    check("rst_m_we",    m_we,    0);
    check("rst_m_addr",  m_addr,  0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_i_ack",   i_ack,   0);
    check("rst_d_ack",   d_ack,   0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_busy",    busy,    0);

    @(negedge clock); reset = 1'b0; #1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); #1;
      check("idle_m_en", m_en, 0);
      check("idle_busy", busy, 0);
      check("idle_stall_if", stall_if, 0);
      check("idle_stall_mem", stall_mem, 0);
    end

    // Fetch only
    @(negedge clock); i_req = 1'b1; i_addr = 32'h40; const_rdata = 32'h8C01_0004; #1;
    check("f0_stall_if", stall_if, 1);
    check("f0_m_en", m_en, 0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock); #1;
      check("f_m_en", m_en, 1);
      check("f_m_addr", m_addr, 32'h40);
      check("f_m_we", m_we, 0);
      check("f_busy", busy, 1);
      check("f_i_ack", i_ack, 0);
    end
    @(negedge clock); #1;
    check("f3_i_ack", i_ack, 1);
    check("f3_m_en", m_en, 0);
    check("f3_i_rdata", i_rdata, 32'h8C01_0004);
    check("f3_stall_if", stall_if, 0);
    @(negedge clock); i_req = 1'b0; #1;
    check("f4_i_ack", i_ack, 0);
    check("f4_busy", busy, 0);

    // Store
    idle_cycles(1);
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; const_rdata = 32'h1234_5678; #1;
    check("s0_stall_mem", stall_mem, 1);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock); #1;
      check("s_m_en", m_en, 1);
      check("s_m_we", m_we, 1);
      check("s_m_addr", m_addr, 32'h20);
      check("s_m_wdata", m_wdata, 32'hDEAD_BEEF);
    end
    @(negedge clock); #1;
    check("s3_d_ack", d_ack, 1);
    check("s3_i_ack", i_ack, 0);
    check("s3_m_we", m_we, 0);
    check("s3_d_rdata", d_rdata, 0);
    check("s3_stall_mem", stall_mem, 0);
    @(negedge clock); d_req = 1'b0; d_we = 1'b0; #1;
    check("s4_d_ack", d_ack, 0);
    check("s4_d_rdata", d_rdata, 0);

    // Simultaneous fetch and data read
    idle_cycles(1);
    use_const = 1'b0;
    @(negedge clock);
    i_req = 1'b1; i_addr = 32'h80; d_req = 1'b1; d_addr = 32'h100; #1;
    @(negedge clock); #1;
    check("b1_m_addr", m_addr, 32'h100);
    check("b1_m_we", m_we, 0);
    idle_cycles(1);
    @(negedge clock); #1;
    check("b3_d_ack", d_ack, 1);
    check("b3_i_ack", i_ack, 0);
    check("b3_d_rdata", d_rdata, 32'h5A5A_0100);
    @(negedge clock); d_req = 1'b0; #1;
    check("b4_busy", busy, 0);
    check("b4_stall_if", stall_if, 1);
    @(negedge clock); #1;
    check("b5_m_en", m_en, 1);
    check("b5_m_addr", m_addr, 32'h80);
    @(negedge clock); #1;
    check("b6_i_ack", i_ack, 0);
    @(negedge clock); #1;
    check("b7_i_ack", i_ack, 1);
    check("b7_d_ack", d_ack, 0);
    check("b7_i_rdata", i_rdata, 32'h5A5A_0080);
    @(negedge clock); i_req = 1'b0; #1;

    // Starvation: both held continuously
    idle_cycles(1);
    @(negedge clock);
    i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_addr = 32'h200; #1;
    prev_en = m_en; gi = 0;
    for (int c = 1; c < 32; c++) begin
      @(negedge clock); #1;
      check("st_i_ack", i_ack, (c == 15 || c == 31) ? 32'd1 : 32'd0);
      check("st_d_ack", d_ack,
            (c == 3 || c == 7 || c == 11 || c == 19 || c == 23 || c == 27) ? 32'd1 : 32'd0);
      check("st_ack_excl", i_ack & d_ack, 0);
      if (m_en && !prev_en && gi < 8) begin
        gdata[gi] = (m_addr == 32'h200);
        gi++;
      end
      prev_en = m_en;
    end
    check("st_grants", gi, 8);
    for (int k = 0; k < 8; k++) begin
      if (k < gi) check("st_order", gdata[k], exp_d[k]);
    end
    @(negedge clock); i_req = 1'b0; d_req = 1'b0; #1;
    check("st_end_busy", busy, 0);
    idle_cycles(1);
    check("st_end_busy2", busy, 0);

    // Reset during the first busy cycle of a fetch
    @(negedge clock); i_req = 1'b1; i_addr = 32'h44; #1;
    @(negedge clock); #1;
    check("r1_m_en", m_en, 1);
    reset = 1'b1;
    @(negedge clock); reset = 1'b0; i_req = 1'b0; #1;
    check("r2_m_en", m_en, 0);
    check("r2_busy", busy, 0);
    check("r2_i_ack", i_ack, 0);
    check("r2_i_rdata", i_rdata, 0);
    @(negedge clock); #1;
    check("r3_i_ack", i_ack, 0);
    check("r3_busy", busy, 0);
    @(negedge clock); i_req = 1'b1; #1;
    idle_cycles(2);
    check("rr2_i_ack", i_ack, 0);
    @(negedge clock); #1;
    check("rr3_i_ack", i_ack, 1);
    check("rr3_i_rdata", i_rdata, 32'h5A5A_0044);
    @(negedge clock); i_req = 1'b0; #1;
    check("rr4_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
